alkmdseq: RTL and testbench
===========================

# alkmdseq

ALK multiply/divide step sequencer: the consumer side of the ALKC microarchitectural carry flag. On a start request it runs 32 ALU iterations. Multiply is shift-and-add; divide is non-restoring, with an optional final correction step. It reads the ALKC flag registered at the end of each step and emits the per-cycle ALU step controls, the shift-in bit and the quotient bits to the DPM datapath.

## Interface
- No parameters.
- qdclk_l  in  1  Clock; all state updates on its rising edge.
- reset_l  in  1  Asynchronous active-low reset.
- mul_start_h  in  1  Start a multiply; sampled in IDLE only.
- div_start_h  in  1  Start a divide; sampled in IDLE only.
- abort_h  in  1  Terminate any operation.
- stall_l  in  1  Low holds the sequencer.
- alkc_flag_h  in  1  ALKC flag; holds the carry/borrow/shift-out of the previous step.
- mq0_h  in  1  Multiplier register LSB for the current step.
- step_add_h  out  1  ALU performs A+B this cycle.
- step_sub_h  out  1  ALU performs A-B this cycle.
- step_shr_h  out  1  Result is shifted right one bit (multiply).
- step_shl_h  out  1  Remainder/quotient is shifted left one bit (divide).
- shr_in_h  out  1  MSB shift-in bit for multiply.
- alu_cin_h  out  1  ALU carry-in.
- quo_bit_h  out  1  Quotient bit; valid when quo_stb_h is high.
- quo_stb_h  out  1  Quotient bit strobe.
- busy_h  out  1  Sequencer is not in IDLE.
- done_h  out  1  One-cycle completion pulse.
- step_cnt_h  out  5  Current step index.

## Operation
- States: IDLE, MUL, DIV, DFIX, DONE. Internal state: 5-bit counter `cnt` and 1-bit flop `last_sub`.
- Reset values: IDLE, cnt=0, last_sub=1. All outputs are 0.
- IDLE transitions:
  - mul_start_h -> MUL.
  - div_start_h alone -> DIV.
  - Both asserted -> MUL (multiply has priority).
  - On either start, cnt=0 and last_sub=1.
- MUL (decode is combinational from state and inputs):
  - step_shr_h=1.
  - step_add_h=mq0_h.
  - shr_in_h = mq0_h ? alkc_flag_h : 0.
  - alu_cin_h=0.
- DIV:
  - q = last_sub ? ~alkc_flag_h : alkc_flag_h.
  - Step 0 always subtracts: step_sub_h=1.
  - Steps 1-31: step_sub_h=q, step_add_h=~q, and quo_bit_h=q with quo_stb_h=1 (bit for the previous step).
  - step_shl_h=1 on every DIV step.
  - alu_cin_h=step_sub_h.
  - At each advancing edge, last_sub captures step_sub_h.
- Counter:
  - Increments on every advancing edge in MUL or DIV.
  - At cnt=31 the next state is DONE (MUL), or DFIX or DONE (DIV, see Configuration).
  - No wrap is visible; cnt clears to 0 on entry to DONE.
- DFIX:
  - quo_stb_h=1, quo_bit_h=q (the final bit).
  - If q=0: step_add_h=1 (remainder restore), no shift.
  - Goes to DONE next edge.
- DONE: done_h=1 for exactly one cycle, then IDLE.
- step_cnt_h=cnt; it reads 0 outside MUL and DIV.
- busy_h=1 in every state except IDLE.

## Timing
- Start latency: start sampled at edge N; the first step's controls are valid in cycle N+1.
- Multiply: 32 step cycles plus DONE. done_h is high 33 cycles after the start edge.
- Divide with correction: 32 steps, DFIX, DONE, i.e. 34 cycles.
- stall_l low:
  - All step_*, quo_stb_h and done_h are forced to 0.
  - State, cnt and last_sub hold.
  - busy_h is unaffected.
- abort_h: IDLE at the next edge, with or without a stall. No done_h is produced. Counter and last_sub return to reset values.
- abort_h has priority over start and stall.
- Start asserted while busy: ignored. It is not queued.
- reset_l asserted mid-operation: immediate return to IDLE with all outputs 0, regardless of clock.
- alkc_flag_h is consumed only as a registered value. No combinational path exists from step outputs back to alkc_flag_h inside this block.

## Configuration
- ALKMDSEQ_DIV_FIX_EN defined: DFIX is present. A divide ends DIV -> DFIX -> DONE, and the final quotient bit plus optional restore are emitted.
- Not defined: DFIX does not exist and DIV step 31 goes directly to DONE. The final quotient bit is emitted in DONE (quo_stb_h=1, quo_bit_h=q); no restore add is issued. Divide takes 33 cycles.

## Test plan
- Reset mid-DIV at step 10: all outputs 0 immediately; IDLE, with step_cnt_h=0 after release.
- mul_start_h pulse with mq0_h=1 on every step and alkc_flag_h=1 -> 32 cycles of step_add_h=1, step_shr_h=1, shr_in_h=1; done_h one cycle later, 33 cycles after start.
- div_start_h with alkc_flag_h=0 constant -> step 0 subtract, then all subtracts with quo_bit_h=1 ×31; with the macro, DFIX quo_bit_h=1 and no add.
- Divide with alkc_flag_h=1 after step 0 and 0 thereafter:
  - step 1: add, quo_bit_h=0.
  - step 2: last_sub=0, so q=alkc=0; add, quo_bit_h=0.
  - Bench checks that polarity tracks last_sub thereafter.
- stall_l low for 5 cycles at MUL step 7: no step strobes and step_cnt_h held at 7; resumes at 7; done_h is delayed by 5 cycles.
- mul_start_h and div_start_h together -> MUL. abort_h at step 20 -> IDLE next edge, and no done_h is produced.

Source files
------------

// File: rtl/alkmdseq.sv
// alkmdseq: multiply/divide step sequencer that consumes the ALKC carry flag.
// Multiply runs 32 shift-and-add steps. Divide runs 32 non-restoring steps.
// Optional feature macro: ALKMDSEQ_DIV_FIX_EN adds the DFIX correction step.
// Without it, the final quotient bit is emitted in DONE.
module alkmdseq (
    input  logic       qdclk_l,
    input  logic       reset_l,
    input  logic       mul_start_h,
    input  logic       div_start_h,
    input  logic       abort_h,
    input  logic       stall_l,
    input  logic       alkc_flag_h,
    input  logic       mq0_h,
    output logic       step_add_h,
    output logic       step_sub_h,
    output logic       step_shr_h,
    output logic       step_shl_h,
    output logic       shr_in_h,
    output logic       alu_cin_h,
    output logic       quo_bit_h,
    output logic       quo_stb_h,
    output logic       busy_h,
    output logic       done_h,
    output logic [4:0] step_cnt_h
);

`ifdef ALKMDSEQ_DIV_FIX_EN
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DFIX, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`endif

    state_t     state_reg, state_next;
    logic [4:0] cnt_reg, cnt_next;
    logic       last_sub_reg, last_sub_next;
    // Remembers that the running operation is a divide, so DONE knows
    // whether it owes the final quotient bit.
    logic       op_div_reg, op_div_next;

    logic       q;
    logic       add_raw, sub_raw, shr_raw, shl_raw;
    logic       shin_raw, qbit_raw, qstb_raw, done_raw;

    // State, step counter and last-operation flop.
    always_ff @(posedge qdclk_l or negedge reset_l) begin
        if (!reset_l) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 5'd0;
            last_sub_reg <= 1'b1;
            op_div_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            last_sub_reg <= last_sub_next;
            op_div_reg   <= op_div_next;
        end
    end

    // Next-state logic and raw (unstalled) step decode.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        last_sub_next = last_sub_reg;
        op_div_next   = op_div_reg;
        add_raw       = 1'b0;
        sub_raw       = 1'b0;
        shr_raw       = 1'b0;
        shl_raw       = 1'b0;
        shin_raw      = 1'b0;
        qbit_raw      = 1'b0;
        qstb_raw      = 1'b0;
        done_raw      = 1'b0;
        // The flag means borrow after a subtract and carry after an add.
        q             = last_sub_reg ? ~alkc_flag_h : alkc_flag_h;

        case (state_reg)
            S_IDLE: begin
                if (stall_l && mul_start_h) begin
                    state_next    = S_MUL;
                    cnt_next      = 5'd0;
                    last_sub_next = 1'b1;
                    op_div_next   = 1'b0;
                end else if (stall_l && div_start_h) begin
                    state_next    = S_DIV;
                    cnt_next      = 5'd0;
                    last_sub_next = 1'b1;
                    op_div_next   = 1'b1;
                end
            end
            S_MUL: begin
                shr_raw  = 1'b1;
                add_raw  = mq0_h;
                shin_raw = mq0_h & alkc_flag_h;
                if (stall_l) begin
                    if (cnt_reg == 5'd31) begin
                        state_next = S_DONE;
                        cnt_next   = 5'd0;
                    end else begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                end
            end
            S_DIV: begin
                shl_raw = 1'b1;
                if (cnt_reg == 5'd0) begin
                    sub_raw = 1'b1;
                end else begin
                    // Bit reported here belongs to the previous step.
                    sub_raw  = q;
                    add_raw  = ~q;
                    qbit_raw = q;
                    qstb_raw = 1'b1;
                end
                if (stall_l) begin
                    last_sub_next = sub_raw;
                    if (cnt_reg == 5'd31) begin
`ifdef ALKMDSEQ_DIV_FIX_EN
                        state_next = S_DFIX;
`else
                        state_next = S_DONE;
`endif
                        cnt_next   = 5'd0;
                    end else begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                end
            end
`ifdef ALKMDSEQ_DIV_FIX_EN
            S_DFIX: begin
                qbit_raw = q;
                qstb_raw = 1'b1;
                // A negative final remainder is restored by adding the divisor back.
                add_raw  = ~q;
                if (stall_l) begin
                    state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done_raw = 1'b1;
`ifndef ALKMDSEQ_DIV_FIX_EN
                if (op_div_reg) begin
                    qbit_raw = q;
                    qstb_raw = 1'b1;
                end
`endif
                if (stall_l) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort wins over start and stall and leaves no trace of the operation.
        if (abort_h) begin
            state_next    = S_IDLE;
            cnt_next      = 5'd0;
            last_sub_next = 1'b1;
            op_div_next   = 1'b0;
        end
    end

    // Output gating: a stall suppresses every strobe but leaves busy alone.
    always_comb begin
        step_add_h = add_raw & stall_l;
        step_sub_h = sub_raw & stall_l;
        step_shr_h = shr_raw & stall_l;
        step_shl_h = shl_raw & stall_l;
        alu_cin_h  = sub_raw & stall_l;
        shr_in_h   = shin_raw;
        quo_bit_h  = qbit_raw;
        quo_stb_h  = qstb_raw & stall_l;
        done_h     = done_raw & stall_l & ~abort_h;
        busy_h     = (state_reg != S_IDLE);
        step_cnt_h = ((state_reg == S_MUL) || (state_reg == S_DIV)) ? cnt_reg : 5'd0;
    end

endmodule

// File: tb/tb_alkmdseq.sv
// tb_alkmdseq: scoreboard bench for the multiply/divide step sequencer.
// Expected output vectors are queued as each cycle's stimulus is driven and
// compared at the falling edge of that cycle.
module tb_alkmdseq;

    logic       qdclk_l = 1'b0;
    logic       reset_l;
    logic       mul_start_h, div_start_h, abort_h, stall_l, alkc_flag_h, mq0_h;
    logic       step_add_h, step_sub_h, step_shr_h, step_shl_h, shr_in_h;
    logic       alu_cin_h, quo_bit_h, quo_stb_h, busy_h, done_h;
    logic [4:0] step_cnt_h;

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q[$];

    alkmdseq dut (
        .qdclk_l     (qdclk_l),
        .reset_l     (reset_l),
        .mul_start_h (mul_start_h),
        .div_start_h (div_start_h),
        .abort_h     (abort_h),
        .stall_l     (stall_l),
        .alkc_flag_h (alkc_flag_h),
        .mq0_h       (mq0_h),
        .step_add_h  (step_add_h),
        .step_sub_h  (step_sub_h),
        .step_shr_h  (step_shr_h),
        .step_shl_h  (step_shl_h),
        .shr_in_h    (shr_in_h),
        .alu_cin_h   (alu_cin_h),
        .quo_bit_h   (quo_bit_h),
        .quo_stb_h   (quo_stb_h),
        .busy_h      (busy_h),
        .done_h      (done_h),
        .step_cnt_h  (step_cnt_h)
    );

    always #5 qdclk_l = ~qdclk_l;

    wire [14:0] obs = {step_add_h, step_sub_h, step_shr_h, step_shl_h, shr_in_h,
                       alu_cin_h, quo_bit_h, quo_stb_h, busy_h, done_h, step_cnt_h};

    // Output vector layout: add sub shr shl shin cin qbit qstb busy done cnt[4:0]
    function automatic logic [14:0] mk(input logic add, input logic sub, input logic shr,
                                       input logic shl, input logic shin, input logic cin,
                                       input logic qb, input logic qs, input logic busy,
                                       input logic dn, input logic [4:0] cnt);
        return {add, sub, shr, shl, shin, cin, qb, qs, busy, dn, cnt};
    endfunction

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (add sub shr shl shin cin qb qs busy done cnt)",
                     tag, got, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; compare mid-cycle, then step.
    task automatic tick(input string tag, input logic [14:0] e);
        exp_q.push_back(e);
        @(negedge qdclk_l);
        check(tag, obs, exp_q.pop_front());
        @(posedge qdclk_l);
        #1;
    endtask

    task automatic run_mul(input logic [31:0] mq, input logic [31:0] fl, input int stall_at,
                           input int stall_len, input int abort_at, input logic both,
                           input int busy_start_at);
        $display("mul op: mq=%h flags=%h stall_at=%0d abort_at=%0d both=%0b",
                 mq, fl, stall_at, abort_at, both);
        mul_start_h = 1'b1;
        div_start_h = both;
        tick("mul_start_idle", 15'd0);
        mul_start_h = 1'b0;
        div_start_h = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    stall_l     = 1'b0;
                    mq0_h       = 1'b0;
                    alkc_flag_h = 1'($urandom);
                    tick($sformatf("mul_stall_%0d", s), mk(0,0,0,0,0,0,0,0,1,0,k[4:0]));
                end
                stall_l = 1'b1;
            end
            if (k == abort_at) begin
                abort_h = 1'b1;
                stall_l = 1'b0;
                mq0_h   = 1'b0;
                tick("mul_abort", mk(0,0,0,0,0,0,0,0,1,0,k[4:0]));
                abort_h = 1'b0;
                stall_l = 1'b1;
                for (int i = 0; i < 3; i++) tick($sformatf("abort_idle_%0d", i), 15'd0);
                return;
            end
            mq0_h       = mq[k];
            alkc_flag_h = fl[k];
            div_start_h = (k == busy_start_at);
            tick($sformatf("mul_step_%0d", k),
                 mk(mq[k],0,1,0,mq[k] & fl[k],0,0,0,1,0,k[4:0]));
            div_start_h = 1'b0;
        end
        tick("mul_done", mk(0,0,0,0,0,0,0,0,1,1,5'd0));
        tick("mul_idle", 15'd0);
    endtask

    task automatic run_div(input logic [32:0] fl, input int reset_at);
        logic ls;
        logic q;
        logic [14:0] e;
        $display("div op: flags=%h reset_at=%0d", fl, reset_at);
        div_start_h = 1'b1;
        tick("div_start_idle", 15'd0);
        div_start_h = 1'b0;
        ls = 1'b1;
        for (int k = 0; k < 32; k++) begin
            alkc_flag_h = fl[k];
            mq0_h       = 1'($urandom);
            if (k == 0) begin
                e  = mk(0,1,0,1,0,1,0,0,1,0,5'd0);
                ls = 1'b1;
            end else begin
                q  = ls ? ~fl[k] : fl[k];
                e  = mk(~q,q,0,1,0,q,q,1,1,0,k[4:0]);
                ls = q;
            end
            if (k == reset_at) begin
                exp_q.push_back(e);
                @(negedge qdclk_l);
                check($sformatf("div_step_%0d", k), obs, exp_q.pop_front());
                #2 reset_l = 1'b0;
                #1 check("reset_async", obs, 15'd0);
                @(posedge qdclk_l);
                #1;
                check("reset_held", obs, 15'd0);
                reset_l = 1'b1;
                tick("post_reset_idle", 15'd0);
                return;
            end
            tick($sformatf("div_step_%0d", k), e);
        end
        alkc_flag_h = fl[32];
        q = ls ? ~fl[32] : fl[32];
`ifdef ALKMDSEQ_DIV_FIX_EN
        tick("div_dfix", mk(~q,0,0,0,0,0,q,1,1,0,5'd0));
        tick("div_done", mk(0,0,0,0,0,0,0,0,1,1,5'd0));
`else
        tick("div_done", mk(0,0,0,0,0,0,q,1,1,1,5'd0));
`endif
        tick("div_idle", 15'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mul_start_h = 1'b0;
        div_start_h = 1'b0;
        abort_h     = 1'b0;
        stall_l     = 1'b1;
        alkc_flag_h = 1'b0;
        mq0_h       = 1'b0;
        reset_l     = 1'b1;
        #1 reset_l  = 1'b0;
        #2 check("reset_state", obs, 15'd0);
        @(posedge qdclk_l);
        #1 reset_l = 1'b1;
        tick("idle_after_reset", 15'd0);

        // Multiply, every step adds with carry shifted in.
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, -1, 1'b0, -1);
        // Random multiply with a 5-cycle stall at step 7 and a start while busy.
        run_mul($urandom, $urandom, 7, 5, -1, 1'b0, 12);
        // Divide, flag constantly clear: all subtracts, quotient bits all 1.
        run_div(33'h0, -1);
        // Divide, flag set only after step 0: switches to add and stays there.
        run_div(33'h2, -1);
        // Random flags: quotient polarity must follow the last operation.
        run_div({$urandom, 1'b0}, -1);
        run_div({$urandom, 1'b1}, -1);
        // Both starts together pick multiply; abort during a stall at step 20.
        run_mul($urandom, $urandom, -1, 0, 20, 1'b1, -1);
        // Asynchronous reset in the middle of a divide.
        run_div({$urandom, 1'b0}, 10);
        // Sequencer is usable again after the reset.
        run_mul($urandom, $urandom, -1, 0, -1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
